scratchpad_feature_mem_ctrl: RTL and testbench
==============================================

// Module: scratchpad_feature_mem_ctrl
// PURPOSE
//  Sequencer for scratchpad_feature_mem: accepts a valid/ready stream of DATA_BUS_WIDTH words,
//  fills cfg_groups x KERNEL_SIZE memory lines, then replays the stored lines to the compute
//  array cfg_repeat times. Sits between the input DMA stream and scratchpad_feature_mem,
//  and drives its wr_*/rd_* ports directly.
// PARAMETERS
//  Tn             `Tn              number of memory groups (1..255)
//  KERNEL_SIZE    `KERNEL_SIZE     lines per group (1..16)
//  DATA_BUS_WIDTH `DATA_BUS_WIDTH  input/write word width
// PORTS
//  clk           in   1    clock
//  rst           in   1    synchronous reset, active-low
//  start         in   1    1-cycle pulse; latches cfg_* and begins a load (IDLE only)
//  cfg_groups    in   8    groups to fill, legal 1..Tn
//  cfg_repeat    in   8    read passes; 0 treated as 1
//  in_valid      in   1    input word valid
//  in_data       in   DBW  input word
//  in_ready      out  1    controller accepts in_data this cycle
//  wr_en         out  1    to mem wr_en
//  wr_mem_group  out  8    to mem wr_mem_group
//  wr_mem_line   out  4    to mem wr_mem_line
//  wr_data       out  DBW  to mem i_port
//  rd_req        in   1    consumer ready for next line (level)
//  rd_en         out  1    to mem rd_en
//  rd_mem_group  out  8    to mem rd_mem_group
//  rd_mem_line   out  4    to mem rd_mem_line
//  rd_last       out  1    with rd_en: final read of final pass
//  busy          out  1    state != IDLE
//  done          out  1    1-cycle pulse after final read
//  cfg_err       out  1    1-cycle pulse: start with cfg_groups==0 or >Tn
// BEHAVIOUR
//  - Reset (rst==0 at edge): state IDLE; all outputs 0, counters 0. Reset mid-operation
//    abandons load/read immediately; mem contents undefined to caller.
//  - States: IDLE -> LOAD -> READ -> IDLE.
//    IDLE: start & legal cfg -> LOAD (latch cfg, wr counters 0). start & illegal -> cfg_err
//      pulse next cycle, stay IDLE. start outside IDLE ignored.
//    LOAD: in_ready = 1 (combinational from state). Handshake in_valid&in_ready ->
//      next cycle wr_en=1, wr_data=in_data, group/line = current counters (registered, 1-cycle
//      latency). Line counter increments; at KERNEL_SIZE-1 wraps to 0 and group++.
//      Word cfg_groups*KERNEL_SIZE accepted -> READ; in_ready drops same edge (never accepts extra).
//      No handshake -> wr_en=0, wr_mem_group/line hold, wr_data holds.
//    READ: order line-outer, group-inner (line 0 grp 0..G-1, line 1 ...). Each cycle with
//      rd_req=1: rd_en=1 with current (group,line) registered, counters advance. rd_req=0:
//      rd_en=0, addresses hold. After group G-1 of line K-1: pass counter++; if passes
//      == max(cfg_repeat,1) -> rd_last=1 on that read, done pulse next cycle, -> IDLE;
//      else counters wrap to (0,0) and next pass follows with no bubble.
//  - First read cycle follows the last write by >=1 cycle (no same-cycle write/read).
//  - Counters: group 8 b, line 4 b, pass 8 b; zero-extend cfg into 16 b for totals.
//  - done and cfg_err never assert together; busy deasserts the cycle done asserts.
// STRUCTURE
//  - Shared package/header network_para.vh: state encodings (ST_IDLE=0, ST_LOAD=1, ST_READ=2),
//    group/line width constants (GRP_W=8, LINE_W=4).
//  - One sub-module natural: kernel_addr_counter (line/group 2-D wrap counter with en, clear,
//    outer/inner order select, wrap flag), instantiated twice (write, read).
// TESTING (Tn=4, KERNEL_SIZE=3)
//  - start cfg_groups=2 cfg_repeat=1, 6 words back-to-back -> wr (g,l) = (0,0)(0,1)(0,2)(1,0)(1,1)(1,2),
//    in_ready low after 6th, then with rd_req=1 reads (0,0)(1,0)(0,1)(1,1)(0,2)(1,2), rd_last on 6th, done +1.
//  - in_valid toggling 1010... during LOAD -> wr_en only the cycle after each handshake, addresses held.
//  - cfg_repeat=3, cfg_groups=1 -> 9 reads, lines 0,1,2 x3 contiguous, single rd_last/done.
//  - cfg_groups=0 and cfg_groups=5 -> cfg_err pulse, busy stays 0, no wr_en.
//  - rst=0 mid-READ (after 2 reads) -> next cycle all outputs 0, IDLE; fresh start works normally.
//  - rd_req low 3 cycles mid-READ; start pulsed during LOAD -> rd_en 0 with held addresses; start ignored.

Source files
------------

// File: rtl/scratchpad_feature_mem_ctrl_pkg.sv
// Shared definitions for the scratchpad feature-memory sequencer.
// Contents: FSM state encoding and the widths of the group, line and pass counters.
package scratchpad_feature_mem_ctrl_pkg;

  localparam int unsigned GRP_W  = 8;
  localparam int unsigned LINE_W = 4;
  localparam int unsigned PASS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2
  } state_e;

endpackage

// File: rtl/scratchpad_feature_mem_ctrl_kernel_addr_counter.sv
// Two-dimensional (group, line) address counter with wrap to (0,0).
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   clr_i         force counter to (0,0)
//   en_i          advance one position
//   grp_inner_i   1: group is the fast index; 0: line is the fast index
//   grp_last_i    highest group index in use
//   line_last_i   highest line index in use
//   grp_o/line_o  current position (registered)
//   wrap_c_o      combinational: current position is the final one
module scratchpad_feature_mem_ctrl_kernel_addr_counter
  import scratchpad_feature_mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              grp_inner_i,
  input  logic [GRP_W-1:0]  grp_last_i,
  input  logic [LINE_W-1:0] line_last_i,
  output logic [GRP_W-1:0]  grp_o,
  output logic [LINE_W-1:0] line_o,
  output logic              wrap_c_o
);

  logic [GRP_W-1:0]  grp_q, grp_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              grp_end, line_end;

  assign grp_end  = (grp_q == grp_last_i);
  assign line_end = (line_q == line_last_i);
  assign wrap_c_o = grp_end && line_end;
  assign grp_o    = grp_q;
  assign line_o   = line_q;

  // Advance the fast index; carry into the slow index when it wraps.
  always_comb begin
    grp_d  = grp_q;
    line_d = line_q;
    if (clr_i) begin
      grp_d  = '0;
      line_d = '0;
    end else if (en_i) begin
      if (grp_inner_i) begin
        if (grp_end) begin
          grp_d  = '0;
          line_d = line_end ? '0 : line_q + LINE_W'(1);
        end else begin
          grp_d  = grp_q + GRP_W'(1);
        end
      end else begin
        if (line_end) begin
          line_d = '0;
          grp_d  = grp_end ? '0 : grp_q + GRP_W'(1);
        end else begin
          line_d = line_q + LINE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grp_q  <= '0;
      line_q <= '0;
    end else begin
      grp_q  <= grp_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/scratchpad_feature_mem_ctrl.sv
// Sequencer for scratchpad_feature_mem: fills cfg_groups x KERNEL_SIZE lines from a
// valid/ready stream, then replays them (line-outer, group-inner) cfg_repeat times.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   start, cfg_groups, cfg_repeat start pulse and configuration (sampled in IDLE)
//   in_valid, in_data, in_ready   input word stream
//   wr_en, wr_mem_group/line, wr_data  memory write port
//   rd_req                        consumer ready (level)
//   rd_en, rd_mem_group/line, rd_last  memory read port
//   busy, done, cfg_err           status
module scratchpad_feature_mem_ctrl
  import scratchpad_feature_mem_ctrl_pkg::*;
#(
  parameter int unsigned Tn             = 4,
  parameter int unsigned KERNEL_SIZE    = 3,
  parameter int unsigned DATA_BUS_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                cfg_groups,
  input  logic [7:0]                cfg_repeat,
  input  logic                      in_valid,
  input  logic [DATA_BUS_WIDTH-1:0] in_data,
  output logic                      in_ready,
  output logic                      wr_en,
  output logic [GRP_W-1:0]          wr_mem_group,
  output logic [LINE_W-1:0]         wr_mem_line,
  output logic [DATA_BUS_WIDTH-1:0] wr_data,
  input  logic                      rd_req,
  output logic                      rd_en,
  output logic [GRP_W-1:0]          rd_mem_group,
  output logic [LINE_W-1:0]         rd_mem_line,
  output logic                      rd_last,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err
);

  localparam logic [LINE_W-1:0] LineLast = LINE_W'(KERNEL_SIZE - 1);

  state_e                    state_q, state_d;
  logic [GRP_W-1:0]          grp_last_q, grp_last_d;
  logic [PASS_W-1:0]         rep_last_q, rep_last_d;
  logic [PASS_W-1:0]         pass_q, pass_d;

  logic                      wr_en_q, wr_en_d, rd_en_q, rd_en_d, rd_last_q, rd_last_d;
  logic                      busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic [GRP_W-1:0]          wr_grp_q, wr_grp_d, rd_grp_q, rd_grp_d;
  logic [LINE_W-1:0]         wr_line_q, wr_line_d, rd_line_q, rd_line_d;
  logic [DATA_BUS_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                      cfg_legal, start_ok, start_bad, wr_fire, rd_fire, final_rd;
  logic [GRP_W-1:0]          wc_grp, rc_grp;
  logic [LINE_W-1:0]         wc_line, rc_line;
  logic                      wc_wrap, rc_wrap;

  assign cfg_legal = (cfg_groups != 8'd0) && (32'(cfg_groups) <= Tn);
  assign start_ok  = start && (state_q == ST_IDLE) && cfg_legal;
  assign start_bad = start && (state_q == ST_IDLE) && !cfg_legal;
  assign in_ready  = (state_q == ST_LOAD);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = (state_q == ST_READ) && rd_req;
  assign final_rd  = rd_fire && rc_wrap && (pass_q == rep_last_q);

  // Write addresses: line fast, group slow.
  scratchpad_feature_mem_ctrl_kernel_addr_counter u_wr_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (start_ok),
    .en_i        (wr_fire),
    .grp_inner_i (1'b0),
    .grp_last_i  (grp_last_q),
    .line_last_i (LineLast),
    .grp_o       (wc_grp),
    .line_o      (wc_line),
    .wrap_c_o    (wc_wrap)
  );

  // Read addresses: group fast, line slow.
  scratchpad_feature_mem_ctrl_kernel_addr_counter u_rd_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (start_ok),
    .en_i        (rd_fire),
    .grp_inner_i (1'b1),
    .grp_last_i  (grp_last_q),
    .line_last_i (LineLast),
    .grp_o       (rc_grp),
    .line_o      (rc_line),
    .wrap_c_o    (rc_wrap)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_LOAD;
      ST_LOAD: if (wr_fire && wc_wrap) state_d = ST_READ;
      ST_READ: if (final_rd) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; addresses and data hold when idle.
  always_comb begin
    wr_en_d    = 1'b0;
    wr_grp_d   = wr_grp_q;
    wr_line_d  = wr_line_q;
    wr_data_d  = wr_data_q;
    rd_en_d    = 1'b0;
    rd_grp_d   = rd_grp_q;
    rd_line_d  = rd_line_q;
    rd_last_d  = 1'b0;
    busy_d     = (state_q != ST_IDLE);
    done_d     = rd_en_q && rd_last_q;
    cfg_err_d  = start_bad;
    grp_last_d = grp_last_q;
    rep_last_d = rep_last_q;
    pass_d     = pass_q;
    if (start_ok) begin
      grp_last_d = cfg_groups - 8'd1;
      rep_last_d = (cfg_repeat == 8'd0) ? '0 : PASS_W'(cfg_repeat - 8'd1);
      pass_d     = '0;
    end
    if (wr_fire) begin
      wr_en_d   = 1'b1;
      wr_grp_d  = wc_grp;
      wr_line_d = wc_line;
      wr_data_d = in_data;
    end
    if (rd_fire) begin
      rd_en_d   = 1'b1;
      rd_grp_d  = rc_grp;
      rd_line_d = rc_line;
      rd_last_d = final_rd;
      if (rc_wrap) pass_d = pass_q + PASS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en_q    <= 1'b0;
      wr_grp_q   <= '0;
      wr_line_q  <= '0;
      wr_data_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_grp_q   <= '0;
      rd_line_q  <= '0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      grp_last_q <= '0;
      rep_last_q <= '0;
      pass_q     <= '0;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_grp_q   <= wr_grp_d;
      wr_line_q  <= wr_line_d;
      wr_data_q  <= wr_data_d;
      rd_en_q    <= rd_en_d;
      rd_grp_q   <= rd_grp_d;
      rd_line_q  <= rd_line_d;
      rd_last_q  <= rd_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      grp_last_q <= grp_last_d;
      rep_last_q <= rep_last_d;
      pass_q     <= pass_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_mem_group = wr_grp_q;
  assign wr_mem_line  = wr_line_q;
  assign wr_data      = wr_data_q;
  assign rd_en        = rd_en_q;
  assign rd_mem_group = rd_grp_q;
  assign rd_mem_line  = rd_line_q;
  assign rd_last      = rd_last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_scratchpad_feature_mem_ctrl.sv
// Directed bench for scratchpad_feature_mem_ctrl with Tn=4, KERNEL_SIZE=3.
module tb_scratchpad_feature_mem_ctrl;

  localparam int TN  = 4;
  localparam int K   = 3;
  localparam int DBW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [7:0]     cfg_groups, cfg_repeat;
  logic           in_valid;
  logic [DBW-1:0] in_data;
  logic           in_ready;
  logic           wr_en;
  logic [7:0]     wr_mem_group;
  logic [3:0]     wr_mem_line;
  logic [DBW-1:0] wr_data;
  logic           rd_req;
  logic           rd_en;
  logic [7:0]     rd_mem_group;
  logic [3:0]     rd_mem_line;
  logic           rd_last, busy, done, cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scratchpad_feature_mem_ctrl #(
    .Tn(TN), .KERNEL_SIZE(K), .DATA_BUS_WIDTH(DBW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_groups(cfg_groups), .cfg_repeat(cfg_repeat),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_mem_group(wr_mem_group), .wr_mem_line(wr_mem_line), .wr_data(wr_data),
    .rd_req(rd_req), .rd_en(rd_en), .rd_mem_group(rd_mem_group), .rd_mem_line(rd_mem_line),
    .rd_last(rd_last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] g, input logic [7:0] r);
    start = 1'b1; cfg_groups = g; cfg_repeat = r;
    tick();
    start = 1'b0;
  endtask

  // Back-to-back words; addresses follow line-fast order.
  task automatic load(input int n, input logic [DBW-1:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + DBW'(i);
      tick();
      chk("wr_en", 32'(wr_en), 1);
      chk("wr_grp", 32'(wr_mem_group), i / K);
      chk("wr_line", 32'(wr_mem_line), i % K);
      chk("wr_data", 32'(wr_data), 32'(base) + i);
    end
    in_valid = 1'b0;
    chk("in_ready_after_load", 32'(in_ready), 0);
    chk("busy_load", 32'(busy), 1);
  endtask

  // Continuous reads; group fast, line slow, repeated passes.
  task automatic rd_seq(input int g, input int passes);
    int total;
    int idx;
    total = g * K * passes;
    rd_req = 1'b1;
    for (int i = 0; i < total; i++) begin
      tick();
      idx = i % (g * K);
      if (i == 0) chk("no_wr_with_first_rd", 32'(wr_en), 0);
      chk("rd_en", 32'(rd_en), 1);
      chk("rd_grp", 32'(rd_mem_group), idx % g);
      chk("rd_line", 32'(rd_mem_line), idx / g);
      chk("rd_last", 32'(rd_last), (i == total - 1) ? 1 : 0);
      chk("busy_read", 32'(busy), 1);
    end
    rd_req = 1'b0;
    tick();
    chk("done_pulse", 32'(done), 1);
    chk("busy_at_done", 32'(busy), 0);
    chk("rd_en_at_done", 32'(rd_en), 0);
    chk("cfg_err_at_done", 32'(cfg_err), 0);
    tick();
    chk("done_clear", 32'(done), 0);
  endtask

  initial begin
    logic [7:0] bad_g [2];
    bad_g[0] = 8'd0;
    bad_g[1] = 8'd5;

    rst = 1'b0; start = 1'b0; cfg_groups = '0; cfg_repeat = '0;
    in_valid = 1'b0; in_data = '0; rd_req = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    rst = 1'b1;
    tick();

    // Two groups, one pass
    do_start(8'd2, 8'd1);
    chk("in_ready_load", 32'(in_ready), 1);
    load(6, 16'h0100);
    rd_seq(2, 1);

    // Toggling in_valid, start pulsed during LOAD is ignored
    do_start(8'd1, 8'd1);
    for (int j = 0; j < 6; j++) begin
      in_valid   = (j % 2 == 0);
      in_data    = 16'h0200 + DBW'(j);
      start      = (j == 1);
      cfg_groups = 8'd2;
      tick();
      start = 1'b0;
      if (j % 2 == 0) begin
        chk("tog_wr_en", 32'(wr_en), 1);
        chk("tog_line", 32'(wr_mem_line), j / 2);
        chk("tog_data", 32'(wr_data), 32'h0200 + j);
      end else begin
        chk("tog_wr_idle", 32'(wr_en), 0);
        chk("tog_line_hold", 32'(wr_mem_line), (j - 1) / 2);
        chk("tog_data_hold", 32'(wr_data), 32'h0200 + j - 1);
      end
      chk("tog_grp", 32'(wr_mem_group), 0);
    end
    in_valid = 1'b0;
    chk("tog_in_ready_done", 32'(in_ready), 0);

    // rd_req stalls for three cycles mid-pass
    rd_req = 1'b1;
    tick();
    chk("stall_rd0", 32'(rd_en), 1);
    chk("stall_line0", 32'(rd_mem_line), 0);
    tick();
    chk("stall_rd1", 32'(rd_en), 1);
    chk("stall_line1", 32'(rd_mem_line), 1);
    rd_req = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_rd_off", 32'(rd_en), 0);
      chk("stall_line_hold", 32'(rd_mem_line), 1);
      chk("stall_grp_hold", 32'(rd_mem_group), 0);
    end
    rd_req = 1'b1;
    tick();
    chk("stall_rd2", 32'(rd_en), 1);
    chk("stall_line2", 32'(rd_mem_line), 2);
    chk("stall_last", 32'(rd_last), 1);
    rd_req = 1'b0;
    tick();
    chk("stall_done", 32'(done), 1);
    tick();

    // One group, three passes
    do_start(8'd1, 8'd3);
    load(3, 16'h0300);
    rd_seq(1, 3);

    // Illegal group counts
    for (int b = 0; b < 2; b++) begin
      start = 1'b1; cfg_groups = bad_g[b]; cfg_repeat = 8'd1;
      tick();
      start = 1'b0;
      chk("bad_cfg_err", 32'(cfg_err), 1);
      chk("bad_busy", 32'(busy), 0);
      chk("bad_in_ready", 32'(in_ready), 0);
      chk("bad_done", 32'(done), 0);
      tick();
      chk("bad_cfg_err_clr", 32'(cfg_err), 0);
      chk("bad_busy2", 32'(busy), 0);
      chk("bad_wr_en", 32'(wr_en), 0);
    end

    // Reset in the middle of READ, then a fresh run
    do_start(8'd2, 8'd1);
    load(6, 16'h0500);
    rd_req = 1'b1;
    tick();
    chk("mid_rd0", 32'(rd_en), 1);
    tick();
    chk("mid_rd1_grp", 32'(rd_mem_group), 1);
    rst = 1'b0;
    tick();
    chk("mrst_rd_en", 32'(rd_en), 0);
    chk("mrst_rd_grp", 32'(rd_mem_group), 0);
    chk("mrst_rd_line", 32'(rd_mem_line), 0);
    chk("mrst_rd_last", 32'(rd_last), 0);
    chk("mrst_wr_en", 32'(wr_en), 0);
    chk("mrst_wr_grp", 32'(wr_mem_group), 0);
    chk("mrst_wr_line", 32'(wr_mem_line), 0);
    chk("mrst_wr_data", 32'(wr_data), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_cfg_err", 32'(cfg_err), 0);
    chk("mrst_in_ready", 32'(in_ready), 0);
    rst = 1'b1; rd_req = 1'b0;
    tick();
    do_start(8'd1, 8'd1);
    chk("fresh_in_ready", 32'(in_ready), 1);
    load(3, 16'h0600);
    rd_seq(1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
